// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared types and defaults for the bit-serial subtractor.
//   sub_state_t   : control FSM states (idle, shifting, result-valid)
//   DEFAULT_WIDTH : default operand/result width
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// half_subtractor
//   One-bit half subtractor. Two of these plus an OR form a full-subtractor cell.
//   x  : minuend bit
//   y  : subtrahend bit
//   d  : difference bit, x ^ y
//   bo : borrow out, ~x & y
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor, diff = a - b, LSB first, one bit
//   per clock. A start/busy/done handshake sequences each operation; results
//   are held from done until the next accepted start.
//   Optional feature macro: SERIAL_SUB_OVERFLOW_EN (adds the ovf port/logic).
//
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only in IDLE
//   a, b   : minuend / subtrahend, captured on an accepted start
//   busy   : high while shifting (WIDTH cycles)
//   done   : one-cycle pulse when diff/borrow are valid
//   diff   : a - b mod 2^WIDTH (partial while busy)
//   borrow : unsigned borrow out, 1 iff a < b
//   ovf    : signed overflow (only with SERIAL_SUB_OVERFLOW_EN)
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  sub_state_t       r_state;
  sub_state_t       w_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_bin;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;
  logic             w_last;

  // Full-subtractor bit cell: two half subtractors plus an OR.
  logic w_d1, w_bo1, w_d, w_bo2, w_bout;

  half_subtractor u_hs0 (
    .x  (r_sa[0]),
    .y  (r_sb[0]),
    .d  (w_d1),
    .bo (w_bo1)
  );

  half_subtractor u_hs1 (
    .x  (w_d1),
    .y  (r_bin),
    .d  (w_d),
    .bo (w_bo2)
  );

  assign w_bout = w_bo1 | w_bo2;

  // Counter holds the number of bits already shifted; the current shift is
  // the last one when WIDTH-1 bits are behind us.
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= (w_nxt == S_SHIFT);
      r_done  <= (w_nxt == S_DONE);
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Operand sign bits are shifted out of sa/sb, so keep them aside.
  logic r_am, r_bm, r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_am  <= 1'b0;
      r_bm  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_am <= a[WIDTH-1];
        r_bm <= b[WIDTH-1];
      end
      // Final d is the result MSB.
      if (r_state == S_SHIFT && w_last)
        r_ovf <= (r_am ^ r_bm) & (r_am ^ w_d);
    end
  end

  assign ovf = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa  <= a;
            r_sb  <= b;
            r_bin <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_sa   <= r_sa >> 1;
          r_sb   <= r_sb >> 1;
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_bin  <= w_bout;
          r_cnt  <= r_cnt + 1'b1;
          // borrow output only moves on the final bit so it holds the
          // previous result through the whole shift.
          if (w_last) r_borrow <= w_bout;
        end
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       st8 = 1'b0, st4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy8, done8, bor8, busy4, done4, bor4;
  logic [7:0] diff8;
  logic [3:0] diff4;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       ovf8, ovf4;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (st8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .diff   (diff8),
    .borrow (bor8)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .ovf    (ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (st4),
    .a      (a4),
    .b      (b4),
    .busy   (busy4),
    .done   (done4),
    .diff   (diff4),
    .borrow (bor4)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .ovf    (ovf4)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one start pulse to the 8-bit DUT; returns negedges until done
  // (0 on timeout) and how many sampled cycles had busy high.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, output int lat, output int nbusy);
    @(negedge clk);
    a8 = ta; b8 = tb_; st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    lat = 0; nbusy = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy8) nbusy++;
      if (done8) begin lat = i; break; end
    end
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, output int lat);
    @(negedge clk);
    a4 = ta; b4 = tb_; st4 = 1'b1;
    @(posedge clk);
    #1 st4 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done4) begin lat = i; break; end
    end
  endtask

  initial begin
    int lat, nb, ndone, last_t;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_diff", 32'(diff8), 0);
    chk("rst_borrow", 32'(bor8), 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_ovf", 32'(ovf8), 0);
`endif
    rst_n = 1'b1;

    // 5 - 3
    op8(8'h05, 8'h03, lat, nb);
    chk("lat_5_3", lat, 9);
    chk("busy_cycles", nb, 8);
    chk("diff_5_3", 32'(diff8), 32'h02);
    chk("bor_5_3", 32'(bor8), 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf_5_3", 32'(ovf8), 0);
`endif
    @(negedge clk);
    chk("done_pulse_1cyc", 32'(done8), 0);
    repeat (3) @(negedge clk);
    chk("diff_hold", 32'(diff8), 32'h02);

    // 3 - 5
    op8(8'h03, 8'h05, lat, nb);
    chk("lat_3_5", lat, 9);
    chk("diff_3_5", 32'(diff8), 32'hFE);
    chk("bor_3_5", 32'(bor8), 1);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf_3_5", 32'(ovf8), 0);
`endif

    // 0x80 - 0x01: signed overflow
    op8(8'h80, 8'h01, lat, nb);
    chk("diff_80_01", 32'(diff8), 32'h7F);
    chk("bor_80_01", 32'(bor8), 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf_80_01", 32'(ovf8), 1);
`endif

    // 0x7F - 0xFF: unsigned borrow and signed overflow
    op8(8'h7F, 8'hFF, lat, nb);
    chk("diff_7f_ff", 32'(diff8), 32'h80);
    chk("bor_7f_ff", 32'(bor8), 1);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf_7f_ff", 32'(ovf8), 1);
`endif

    // Start pulse while busy must be ignored
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done8) begin lat = i; break; end
    end
    chk("ign_seen_done", 32'(lat != 0), 1);
    chk("ign_diff", 32'(diff8), 32'h02);
    repeat (3) @(negedge clk);
    chk("ign_no_restart", 32'(busy8), 0);

    // 0 - 0 with start held high for 30 cycles
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h00; st8 = 1'b1;
    ndone = 0; last_t = 0;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        chk("held_diff", 32'(diff8), 0);
        chk("held_bor", 32'(bor8), 0);
        if (last_t != 0) chk("held_period", t - last_t, 10);
        last_t = t;
      end
    end
    chk("held_ndone", ndone, 3);
    st8 = 1'b0;
    repeat (12) @(negedge clk);

    // Reset during the 4th SHIFT cycle of 0xFF - 0x01
    op8(8'h03, 8'h05, lat, nb);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_done", 32'(done8), 0);
    chk("abort_diff", 32'(diff8), 0);
    chk("abort_bor", 32'(bor8), 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("abort_ovf", 32'(ovf8), 0);
`endif
    nb = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nb += int'(done8) + int'(busy8);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nb += int'(done8) + int'(busy8);
    end
    chk("abort_stays_idle", nb, 0);
    op8(8'hFF, 8'h01, lat, nb);
    chk("lat_ff_01", lat, 9);
    chk("diff_ff_01", 32'(diff8), 32'hFE);
    chk("bor_ff_01", 32'(bor8), 0);

    // Exhaustive 4-bit sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        op4(4'(i), 4'(j), lat);
        if (lat != 5) chk("w4_lat", lat, 5);
        chk("w4_diff", 32'(diff4), (i - j) & 15);
        chk("w4_bor", 32'(bor4), (i < j) ? 1 : 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
